// File: rtl/xst_txq_if.sv
// ---------------------------------------------------------------------------
// xst_txq_if
//
// Host-side bundle for the xst_txq queued serial transmitter.
//
// Host -> transmitter:
//   dat_i      frame bit image (start/data/parity/stop already packed)
//   bits_i     number of bit cells to send from dat_i
//   txreg_we_i push request, one frame per asserted cycle
//   txbaud_i   bit cell length minus one, in clocks
// Transmitter -> host:
//   txd_o      serial output line
//   idle_o     shifter and queue both empty
//   brg_o      current baud down-counter
//   full_o     queue holds DEPTH frames
//   level_o    frames waiting in the queue (not counting the one shifting)
//   ovr_o      one-cycle pulse when a push was dropped on a full queue
//
// master: the host (or a testbench); slave: the transmitter.
// ---------------------------------------------------------------------------
interface xst_txq_if #(
  parameter int SR_WIDTH  = 64,
  parameter int BITS_W    = 7,
  parameter int BRG_WIDTH = 16,
  parameter int DEPTH     = 4
);
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  logic [SR_WIDTH-1:0]  dat_i;
  logic [BITS_W-1:0]    bits_i;
  logic                 txreg_we_i;
  logic [BRG_WIDTH-1:0] txbaud_i;

  logic                 txd_o;
  logic                 idle_o;
  logic [BRG_WIDTH-1:0] brg_o;
  logic                 full_o;
  logic [LEVEL_W-1:0]   level_o;
  logic                 ovr_o;

  modport master (
    output dat_i, bits_i, txreg_we_i, txbaud_i,
    input  txd_o, idle_o, brg_o, full_o, level_o, ovr_o
  );

  modport slave (
    input  dat_i, bits_i, txreg_we_i, txbaud_i,
    output txd_o, idle_o, brg_o, full_o, level_o, ovr_o
  );
endinterface

// File: rtl/xst_txq.sv
// ---------------------------------------------------------------------------
// xst_txq
//
// Queued serial transmitter. The host posts pre-formatted frame images
// together with a bit count; frames are shifted out on txd_o one bit cell
// at a time, each cell lasting txbaud_i+1 clocks. A DEPTH-entry queue lets
// several frames be posted back-to-back; a new frame starts on the very
// edge that ends the previous one, so there is no gap on the line.
//
// Ports:
//   clk_i    sole clock, rising edge
//   reset_i  synchronous, active-high reset
//   bus      xst_txq_if slave modport (host data/control in, status out)
//
// Parameters:
//   SR_WIDTH  frame image / shift register width (>= 2)
//   BITS_W    width of the bit count, must be able to hold SR_WIDTH
//   BRG_WIDTH baud counter width
//   DEPTH     queue entries (power of two, >= 2)
//   LSB_FIRST 1: bit 0 leaves first; 0: bit SR_WIDTH-1 leaves first
// ---------------------------------------------------------------------------
module xst_txq #(
  parameter int SR_WIDTH  = 64,
  parameter int BITS_W    = 7,
  parameter int BRG_WIDTH = 16,
  parameter int DEPTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic     clk_i,
  input logic     reset_i,
  xst_txq_if.slave bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = $clog2(DEPTH + 1);

  localparam logic [BITS_W-1:0]  MAX_BITS   = BITS_W'(SR_WIDTH);
  localparam logic [BITS_W-1:0]  ONE_BIT    = BITS_W'(1);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] ONE_LEVEL  = LEVEL_W'(1);
  localparam logic [PTR_W-1:0]   ONE_PTR    = PTR_W'(1);
  localparam logic [BRG_WIDTH-1:0] ONE_BRG  = BRG_WIDTH'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // Shifter, baud counter and remaining-bit counter of the frame on the wire.
  logic [SR_WIDTH-1:0]  shreg;
  logic [BRG_WIDTH-1:0] brg;
  logic [BITS_W-1:0]    bitcnt;

  // Frame queue storage and bookkeeping.
  logic [SR_WIDTH-1:0] q_dat  [DEPTH];
  logic [BITS_W-1:0]   q_bits [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [LEVEL_W-1:0]  level;
  logic                ovr;

  logic                push_req;
  logic [BITS_W-1:0]   push_bits;
  logic                q_empty;
  logic                q_full;

  logic                bit_end;
  logic                frame_end;
  logic                do_pop;
  logic                do_bypass;
  logic                do_write;
  logic                do_drop;
  logic                load;
  logic [SR_WIDTH-1:0] load_dat;
  logic [BITS_W-1:0]   load_bits;

  assign q_empty = (level == '0);
  assign q_full  = (level == FULL_LEVEL);

  // Push qualification: oversize counts are clamped to the register width,
  // and a zero-length frame is not a push at all (no entry, no overflow).
  always_comb begin
    push_bits = bus.bits_i;
    if (bus.bits_i > MAX_BITS) begin
      push_bits = MAX_BITS;
    end
    push_req = bus.txreg_we_i && (bus.bits_i != '0);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and transfer decisions. A frame ends on the edge where the
  // last bit cell's counter is zero; the queue head takes priority over a
  // fresh push so frames leave in posting order.
  always_comb begin
    state_next = state;
    bit_end    = 1'b0;
    frame_end  = 1'b0;
    do_pop     = 1'b0;
    do_bypass  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!q_empty) begin
          do_pop     = 1'b1;
          state_next = ST_SHIFT;
        end else if (push_req) begin
          do_bypass  = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_end   = (brg == '0);
        frame_end = bit_end && (bitcnt == ONE_BIT);
        if (frame_end) begin
          if (!q_empty) begin
            do_pop = 1'b1;
          end else if (push_req) begin
            do_bypass = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // A push that is not loaded straight into the shifter goes to the queue.
  // A simultaneous pop frees a slot, so a full queue still accepts it.
  always_comb begin
    do_write  = push_req && !do_bypass && (!q_full || do_pop);
    do_drop   = push_req && !do_bypass && q_full && !do_pop;
    load      = do_pop || do_bypass;
    load_dat  = bus.dat_i;
    load_bits = push_bits;
    if (do_pop) begin
      load_dat  = q_dat[head];
      load_bits = q_bits[head];
    end
  end

  // Shifter datapath. Loading a frame restarts the baud counter from
  // txbaud_i; at each bit end the register moves toward the output end,
  // back-filling with idle-level ones, and the baud value is re-sampled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shreg  <= '0;
      brg    <= '0;
      bitcnt <= '0;
    end else if (load) begin
      shreg  <= load_dat;
      bitcnt <= load_bits;
      brg    <= bus.txbaud_i;
    end else if (state == ST_SHIFT) begin
      if (!bit_end) begin
        brg <= brg - ONE_BRG;
      end else if (frame_end) begin
        shreg  <= '0;
        brg    <= '0;
        bitcnt <= '0;
      end else begin
        if (LSB_FIRST) begin
          shreg <= {1'b1, shreg[SR_WIDTH-1:1]};
        end else begin
          shreg <= {shreg[SR_WIDTH-2:0], 1'b1};
        end
        bitcnt <= bitcnt - ONE_BIT;
        brg    <= bus.txbaud_i;
      end
    end
  end

  // Queue storage. Contents need no reset: the level counter decides
  // which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      q_dat[tail]  <= bus.dat_i;
      q_bits[tail] <= push_bits;
    end
  end

  // Queue pointers, occupancy and the overflow pulse. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head  <= '0;
      tail  <= '0;
      level <= '0;
      ovr   <= 1'b0;
    end else begin
      ovr <= do_drop;
      if (do_write) begin
        tail <= tail + ONE_PTR;
      end
      if (do_pop) begin
        head <= head + ONE_PTR;
      end
      case ({do_write, do_pop})
        2'b10:   level <= level + ONE_LEVEL;
        2'b01:   level <= level - ONE_LEVEL;
        default: level <= level;
      endcase
    end
  end

  // Line and status outputs. The line rests high whenever nothing shifts.
  always_comb begin
    bus.txd_o = 1'b1;
    if (state == ST_SHIFT) begin
      bus.txd_o = LSB_FIRST ? shreg[0] : shreg[SR_WIDTH-1];
    end
    bus.brg_o   = brg;
    bus.idle_o  = (state == ST_IDLE) && q_empty;
    bus.full_o  = q_full;
    bus.level_o = level;
    bus.ovr_o   = ovr;
  end

endmodule

// File: doc/xst_txq.md
# xst_txq

Parametrised successor to the `xst` serial transmitter. It adds a frame queue so software can post several frames back-to-back, with variable shift-register width and a selectable bit order. Each frame is a pre-formatted bit image (start, data, parity and stop bits already packed by the host) plus a per-frame bit count. The block sits between the host data bus and the `txd_o` pad.

## Interface
- `SR_WIDTH`, 64, width of frame image and shift register (≥2)
- `BITS_W`, 7, width of `bits_i`; must hold `SR_WIDTH`
- `BRG_WIDTH`, 16, baud generator width
- `DEPTH`, 4, queue entries (power of two, ≥2)
- `LSB_FIRST`, 1, 1 = shift out bit 0 first; 0 = bit `SR_WIDTH-1` first
- `clk_i` in 1: sole clock; all state updates on rising edge
- `reset_i` in 1: synchronous, active-high reset
- `dat_i` in SR_WIDTH: frame image
- `bits_i` in BITS_W: number of bit cells to send from `dat_i`
- `txreg_we_i` in 1: push request, one frame per asserted cycle
- `txbaud_i` in BRG_WIDTH: bit cell length minus one, in clocks
- `txd_o` out 1: serial output
- `idle_o` out 1: shifter and queue both empty
- `brg_o` out BRG_WIDTH: current baud down-counter
- `full_o` out 1: queue holds `DEPTH` frames
- `level_o` out clog2(DEPTH+1): frames held in the queue, excluding the one shifting
- `ovr_o` out 1: one-cycle pulse when a push is dropped because the queue is full

## Operation
- **State: IDLE / SHIFT.**
  - IDLE: `txd_o`=1, `brg_o`=0, `idle_o`=1 when `level_o`=0.
  - SHIFT: `txd_o` = current output bit of the shifter; `idle_o`=0.
- **Bit-count handling on push.**
  - `bits_i` > `SR_WIDTH` is clamped to `SR_WIDTH`.
  - A push with `bits_i`=0 is discarded silently: no queue entry, no `ovr_o`.
- **Push in IDLE with queue empty (bypass).** The frame loads straight into the shifter: `brg` ← `txbaud_i`, `bitcnt` ← bits, state → SHIFT.
- **Push otherwise.** The frame `{dat_i, clamped bits}` is written to the queue tail.
  - If the queue is full and no pop occurs that cycle, the frame is dropped and `ovr_o`=1 for the next cycle.
- **Bit cells in SHIFT.**
  - `brg` decrements each cycle while nonzero.
  - When `brg`=0, the bit ends at that edge: shift the register toward the output end, filling with 1; `bitcnt` ← `bitcnt`−1; `brg` ← `txbaud_i`. `txbaud_i` is re-sampled at every bit start.
- **Frame end** (`brg`=0 and `bitcnt`=1), taking the first matching case:
  - Queue nonempty: pop the head into the shifter at the same edge. No idle cycle between frames.
  - Queue empty and a push is present this cycle: bypass-load it.
  - Otherwise: → IDLE.
- **Push and pop in the same cycle.** Both take effect. `level_o` is unchanged. A push into a full queue coinciding with a pop is accepted.
- `level_o` and `full_o` reflect registered queue state.
- **Reset** (any cycle, including mid-frame): queue emptied, shifter cleared, state IDLE, `txd_o`=1, `idle_o`=1, `brg_o`=0, `full_o`=0, `level_o`=0, `ovr_o`=0.

## Timing
- **Push-to-output latency, bypass case:** write sampled at edge N. After N: `txd_o` = first bit, `brg_o` = `txbaud_i`, `idle_o`=0.
- **Bit cell length:** exactly `txbaud_i`+1 clocks, with `brg_o` showing `txbaud_i` … 0.
  - `txbaud_i`=0 gives one clock per bit.
- **Frame length:** `bits`×(`txbaud_i`+1) clocks.
  - `idle_o` rises on the edge that ends the last bit cell, if nothing is pending.
- **Back-to-back frames:** the first bit of frame k+1 immediately follows the last `brg`=0 cycle of frame k.
- **Queue status:** `full_o` and `level_o` update one edge after the push or pop.

## Test plan
- **Single frame, bypass.**
  - Stimulus: reset, then push `dat_i`=…1_1_00010001_0, `bits_i`=11, `txbaud_i`=4.
  - Response: `txd_o` 0,1,0,0,0,1,0,0,0,1,1, each bit held 5 clocks with `brg_o` 4→0. `idle_o`=1 on the next edge.
- **Back-to-back.**
  - Stimulus: push frames A=0x…5 (4 bits) and B=0x…A (4 bits) on consecutive cycles, `txbaud_i`=1.
  - Response: `txd_o` 1,0,1,0,0,1,0,1, each bit for 2 clocks with no gap. `level_o` goes 1 then 0 at the A→B transition.
- **Overflow.**
  - Stimulus: push DEPTH+2 frames on consecutive cycles while the first is shifting.
  - Response: `full_o`=1 after DEPTH queued, one `ovr_o` pulse for the dropped frame, and exactly DEPTH+1 frames are transmitted.
- **Full queue, push coinciding with frame-end pop.** Response: push accepted, `ovr_o` stays 0, `level_o` stays DEPTH.
- **Bits edge cases.**
  - `bits_i`=0: ignored, `idle_o` stays 1.
  - `bits_i`=100 with `SR_WIDTH`=64: exactly 64 bit cells are sent.
  - `LSB_FIRST`=0 with `dat_i`=0x8000…0001, `bits_i`=2: `txd_o` 1 then 0.
- **Reset mid-frame.** Stimulus: assert `reset_i` during bit 3 with 2 frames queued. Response: next cycle `txd_o`=1, `idle_o`=1, `level_o`=0, and no further transmission.
